// File: rtl/spi_periph_bridge_if.sv
// Signal bundle between the SPI register front end, the bridge and the peripheral bus.
// master = bridge side, slave = front end / peripheral side.
interface spi_periph_bridge_if #(
  parameter int ADDR_W = 6,
  parameter int REG_W  = 32
);
  logic [ADDR_W-1:0] reg_addr;
  logic              reg_rw;
  logic [1:0]        txn_width;
  logic [REG_W-1:0]  reg_data_o;
  logic              reg_data_o_dv;
  logic              reg_addr_v;
  logic [REG_W-1:0]  reg_data_i;
  logic              reg_data_i_dv;
  logic [ADDR_W-1:0] address;
  logic [REG_W-1:0]  data_in;
  logic [1:0]        data_write_n;
  logic [1:0]        data_read_n;
  logic [REG_W-1:0]  data_out;
  logic              data_ready;
  logic              timeout_err;

  modport master (
    input  reg_addr, reg_rw, txn_width, reg_data_o, reg_data_o_dv, reg_addr_v,
           data_out, data_ready,
    output reg_data_i, reg_data_i_dv, address, data_in, data_write_n, data_read_n,
           timeout_err
  );

  modport slave (
    output reg_addr, reg_rw, txn_width, reg_data_o, reg_data_o_dv, reg_addr_v,
           data_out, data_ready,
    input  reg_data_i, reg_data_i_dv, address, data_in, data_write_n, data_read_n,
           timeout_err
  );
endinterface

// File: rtl/spi_periph_bridge.sv
// Converts SPI front-end write strobes / read requests into single TinyQV-style
// peripheral bus cycles and returns read data with a one-cycle valid pulse.
//
// state | meaning
// IDLE  | waiting for a write strobe or read request
// WRITE | data_write_n active for exactly one cycle
// READ  | data_read_n active, waiting for data_ready or timeout
// RESP  | reg_data_i_dv high for one cycle
// HOLD  | waiting for the front end to drop reg_addr_v
module spi_periph_bridge #(
  parameter int ADDR_W = 6,
  parameter int REG_W  = 32,
  parameter int TO_CYC = 255
) (
  input logic               clk,
  input logic               rst,
  input logic               ena,
  spi_periph_bridge_if.master bus
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, RESP, HOLD} state_t;

  localparam logic [7:0] TO_LIM = 8'(TO_CYC);

  state_t            state_q, state_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [REG_W-1:0]  din_q, din_nx;
  logic [1:0]        wr_n_q, wr_n_nx;
  logic [1:0]        rd_n_q, rd_n_nx;
  logic [REG_W-1:0]  rdata_q, rdata_nx;
  logic              dv_q, dv_nx;
  logic              err_q, err_nx;
  logic [7:0]        cnt_q, cnt_nx;
  logic [1:0]        w;
  logic [REG_W-1:0]  rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      din_q   <= '0;
      wr_n_q  <= 2'b11;
      rd_n_q  <= 2'b11;
      rdata_q <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else if (ena) begin
      state_q <= state_nx;
      addr_q  <= addr_nx;
      din_q   <= din_nx;
      wr_n_q  <= wr_n_nx;
      rd_n_q  <= rd_n_nx;
      rdata_q <= rdata_nx;
      dv_q    <= dv_nx;
      err_q   <= err_nx;
      cnt_q   <= cnt_nx;
    end
  end

  always_comb begin
    w = (bus.txn_width == 2'b11) ? 2'b10 : bus.txn_width;
    // Mask by the width currently on the bus, which is the width of this read
    case (rd_n_q)
      2'b00:   rd_data = bus.data_out & REG_W'(8'hFF);
      2'b01:   rd_data = bus.data_out & REG_W'(16'hFFFF);
      default: rd_data = bus.data_out;
    endcase

    state_nx = state_q;
    addr_nx  = addr_q;
    din_nx   = din_q;
    wr_n_nx  = wr_n_q;
    rd_n_nx  = rd_n_q;
    rdata_nx = rdata_q;
    dv_nx    = 1'b0;
    err_nx   = err_q;
    cnt_nx   = cnt_q;

    if (bus.reg_data_o_dv && bus.reg_rw && state_q != IDLE) err_nx = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.reg_data_o_dv && bus.reg_rw) begin
          addr_nx  = bus.reg_addr;
          din_nx   = bus.reg_data_o;
          wr_n_nx  = w;
          state_nx = WRITE;
        end else if (bus.reg_addr_v) begin
          addr_nx  = bus.reg_addr;
          rd_n_nx  = w;
          cnt_nx   = 8'd0;
          state_nx = READ;
        end
      end
      WRITE: begin
        wr_n_nx  = 2'b11;
        state_nx = IDLE;
      end
      READ: begin
        if (bus.data_ready) begin
          rdata_nx = rd_data;
          rd_n_nx  = 2'b11;
          dv_nx    = 1'b1;
          state_nx = RESP;
        end else if (cnt_q == TO_LIM) begin
          rdata_nx = '0;
          err_nx   = 1'b1;
          rd_n_nx  = 2'b11;
          dv_nx    = 1'b1;
          state_nx = RESP;
        end else if (cnt_q != 8'hFF) begin
          cnt_nx = cnt_q + 8'd1;
        end
      end
      RESP: state_nx = HOLD;
      HOLD: if (!bus.reg_addr_v) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.address       = addr_q;
  assign bus.data_in       = din_q;
  assign bus.data_write_n  = wr_n_q;
  assign bus.data_read_n   = rd_n_q;
  assign bus.reg_data_i    = rdata_q;
  assign bus.reg_data_i_dv = dv_q;
  assign bus.timeout_err   = err_q;
endmodule
